// File: rtl/trivium_lite_pkg.sv
// Shared constants for the trivium_lite keystream tiles: register lengths, taps, seed-load values
// and the receive FSM state encoding.
package trivium_lite_pkg;

  localparam int unsigned ALen = 31;
  localparam int unsigned BLen = 29;
  localparam int unsigned CLen = 36;

  localparam int unsigned ATapOut = 30;
  localparam int unsigned ATapMid = 17;
  localparam int unsigned AAndHi  = 29;
  localparam int unsigned AAndLo  = 28;
  localparam int unsigned ATapFb  = 26;

  localparam int unsigned BTapOut = 28;
  localparam int unsigned BTapMid = 13;
  localparam int unsigned BAndHi  = 27;
  localparam int unsigned BAndLo  = 26;
  localparam int unsigned BTapFb  = 24;

  localparam int unsigned CTapOut = 35;
  localparam int unsigned CTapMid = 20;
  localparam int unsigned CAndHi  = 34;
  localparam int unsigned CAndLo  = 33;
  localparam int unsigned CTapFb  = 29;

  localparam logic [CLen-1:0] CInit = {3'b111, 33'b0};

  localparam int unsigned WarmupDefault = 128;

  typedef enum logic [2:0] {
    StIdle,
    StWarmup,
    StReady,
    StCrypt,
    StHold
  } rx_state_e;

endpackage

// File: rtl/trivium_lite_ks_core.sv
// 96-bit trivium_lite keystream generator; z_o is the bit of the current state, consumed on step_i.
module trivium_lite_ks_core
  import trivium_lite_pkg::*;
(
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [7:0] seed_i,
  output logic       z_o
);

  logic [ALen-1:0] a_q;
  logic [BLen-1:0] b_q;
  logic [CLen-1:0] c_q;
  logic            t1, t2, t3, n1, n2, n3;

  always_comb begin
    t1  = a_q[ATapOut] ^ a_q[ATapMid];
    t2  = b_q[BTapOut] ^ b_q[BTapMid];
    t3  = c_q[CTapOut] ^ c_q[CTapMid];
    z_o = t1 ^ t2 ^ t3;
    n1  = t1 ^ (a_q[AAndHi] & a_q[AAndLo]) ^ b_q[BTapFb];
    n2  = t2 ^ (b_q[BAndHi] & b_q[BAndLo]) ^ c_q[CTapFb];
    n3  = t3 ^ (c_q[CAndHi] & c_q[CAndLo]) ^ a_q[ATapFb];
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else if (load_i) begin
      a_q <= {23'b0, seed_i};
      b_q <= {21'b0, ~seed_i};
      c_q <= CInit;
    end else if (step_i) begin
      a_q <= {a_q[ALen-2:0], n3};
      b_q <= {b_q[BLen-2:0], n1};
      c_q <= {c_q[CLen-2:0], n2};
    end
  end

endmodule

// File: rtl/trivium_lite_rx_decrypt.sv
// Receive-side trivium_lite decryptor: seed, warm up, then XOR 8 keystream bits onto each byte.
// Optional TRIVIUM_RX_BYTE_COUNT_EN adds a 16-bit delivered-byte counter port.
module trivium_lite_rx_decrypt
  import trivium_lite_pkg::*;
#(
  parameter int unsigned WARMUP = WarmupDefault
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        seed_valid_i,
  input  logic [7:0]  seed_i,
  output logic        seed_ready_o,
  input  logic        resync_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [7:0]  out_data_o,
  input  logic        out_ready_i,
`ifdef TRIVIUM_RX_BYTE_COUNT_EN
  output logic [15:0] byte_count_o,
`endif
  output logic        busy_o
);

  localparam logic [9:0] WarmupLast = 10'(WARMUP - 1);

  rx_state_e  state_q;
  logic [9:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] ks_q;
  logic [7:0] in_byte_q;
  logic       out_valid_q;
  logic       z;
  logic       clr, load, step;

  // Resync outranks everything, including a seed load in the same cycle.
  assign clr  = rst_i | resync_i;
  assign load = seed_valid_i & seed_ready_o;
  assign step = (state_q == StWarmup) | (state_q == StCrypt);

  trivium_lite_ks_core u_ks_core (
    .clk_i  (clk_i),
    .clr_i  (clr),
    .load_i (load),
    .step_i (step),
    .seed_i (seed_i),
    .z_o    (z)
  );

  always_ff @(posedge clk_i) begin
    if (clr) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      ks_q        <= '0;
      in_byte_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (seed_valid_i) begin
            state_q <= StWarmup;
            cnt_q   <= '0;
            bit_q   <= '0;
          end
        end
        StWarmup: begin
          if (cnt_q == WarmupLast) state_q <= StReady;
          else                     cnt_q   <= cnt_q + 10'd1;
        end
        StReady: begin
          if (seed_valid_i) begin
            state_q <= StWarmup;
            cnt_q   <= '0;
            bit_q   <= '0;
          end else if (in_valid_i) begin
            state_q   <= StCrypt;
            in_byte_q <= in_data_i;
            bit_q     <= '0;
          end
        end
        StCrypt: begin
          // First keystream bit ends up in bit 7 after eight shifts.
          ks_q  <= {ks_q[6:0], z};
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_q     <= StHold;
            out_valid_q <= 1'b1;
          end
        end
        StHold: begin
          if (out_ready_i) begin
            state_q     <= StReady;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign seed_ready_o = (state_q == StIdle) | (state_q == StReady);
  assign in_ready_o   = (state_q == StReady);
  assign busy_o       = step;
  assign out_valid_o  = out_valid_q;
  // Both operands are frozen while in HOLD, so the plaintext stays stable under backpressure.
  assign out_data_o   = in_byte_q ^ ks_q;

`ifdef TRIVIUM_RX_BYTE_COUNT_EN
  logic [15:0] byte_count_q;

  always_ff @(posedge clk_i) begin
    if (clr || load)                      byte_count_q <= '0;
    else if (out_valid_q && out_ready_i)  byte_count_q <= byte_count_q + 16'd1;
  end

  assign byte_count_o = byte_count_q;
`endif

endmodule

// File: tb/tb_trivium_lite_rx_decrypt.sv
// Self-checking bench for trivium_lite_rx_decrypt against a bit-serial keystream reference model.
// Exercises TRIVIUM_RX_BYTE_COUNT_EN when that macro is defined.
module tb_trivium_lite_rx_decrypt;

  localparam int WARMUP = 128;
  localparam int NBytes = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_valid = 1'b0;
  logic [7:0]  seed = 8'h00;
  logic        seed_ready;
  logic        resync = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b1;
  logic        busy;
`ifdef TRIVIUM_RX_BYTE_COUNT_EN
  logic [15:0] byte_count;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] mks [NBytes];

  always #5 clk = ~clk;

  trivium_lite_rx_decrypt #(.WARMUP(WARMUP)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .seed_valid_i (seed_valid),
    .seed_i       (seed),
    .seed_ready_o (seed_ready),
    .resync_i     (resync),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_ready_o   (in_ready),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_ready_i  (out_ready),
`ifdef TRIVIUM_RX_BYTE_COUNT_EN
    .byte_count_o (byte_count),
`endif
    .busy_o       (busy)
  );

  // Reference keystream: one z bit per step, first WARMUP bits dropped, then packed MSB-first.
  task automatic model_gen(input logic [7:0] s);
    logic [30:0] a;
    logic [28:0] b;
    logic [35:0] c;
    logic t1, t2, t3, z, n1, n2, n3;
    int k;
    a = {23'b0, s};
    b = {21'b0, ~s};
    c = {3'b111, 33'b0};
    for (int i = 0; i < WARMUP + 8 * NBytes; i++) begin
      t1 = a[30] ^ a[17];
      t2 = b[28] ^ b[13];
      t3 = c[35] ^ c[20];
      z  = t1 ^ t2 ^ t3;
      n1 = t1 ^ (a[29] & a[28]) ^ b[24];
      n2 = t2 ^ (b[27] & b[26]) ^ c[29];
      n3 = t3 ^ (c[34] & c[33]) ^ a[26];
      a  = {a[29:0], n3};
      b  = {b[27:0], n1};
      c  = {c[34:0], n2};
      if (i >= WARMUP) begin
        k = i - WARMUP;
        mks[k / 8][7 - (k % 8)] = z;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a seed load; returns cycles until in_ready (or -1 on timeout), optionally skipping the wait.
  task automatic load_seed(input logic [7:0] s, input bit wait_ready, output int warm);
    int n;
    n = 0;
    while (!seed_ready && n < 4000) begin tick(); n++; end
    seed = s;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    model_gen(s);
    warm = 0;
    if (wait_ready) begin
      while (!in_ready && warm < 4000) begin tick(); warm++; end
      if (warm >= 4000) warm = -1;
    end
  endtask

  // Push one ciphertext byte and wait for its plaintext; lat counts edges from the in-handshake.
  task automatic xfer(input logic [7:0] ct, input bit consume, output logic [7:0] got,
                      output int lat);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = ct;
    while (!in_ready && n < 4000) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin tick(); lat++; end
    if (n >= 4000) lat = -1;
    got = out_data;
    if (consume) begin
      out_ready = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset();
    checks++;
    if (seed_ready !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== 8'h00) begin
      failures++;
      $display("FAIL reset: seed_ready=%b in_ready=%b busy=%b out_valid=%b out_data=%02h, required 1 0 0 0 00",
               seed_ready, in_ready, busy, out_valid, out_data);
    end
  endtask

  task automatic test_known_vector();
    logic [7:0] pt [4];
    logic [7:0] got;
    int lat, warm;
    pt[0] = 8'hDE; pt[1] = 8'hAD; pt[2] = 8'hBE; pt[3] = 8'hEF;
    load_seed(8'h76, 1'b0, warm);
    checks++;
    if (busy !== 1'b1 || seed_ready !== 1'b0) begin
      failures++;
      $display("FAIL warmup_flags: busy=%b seed_ready=%b, required 1 0", busy, seed_ready);
    end
    // A seed offered while busy must be ignored.
    seed = 8'h55;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    warm = 1;
    while (!in_ready && warm < 4000) begin tick(); warm++; end
    checks++;
    if (warm != WARMUP) begin
      failures++;
      $display("FAIL warmup_len: cycles=%0d, required %0d", warm, WARMUP);
    end
    for (int i = 0; i < 4; i++) begin
      xfer(pt[i] ^ mks[i], 1'b1, got, lat);
      checks++;
      if (got !== pt[i] || lat != 8) begin
        failures++;
        $display("FAIL known_byte%0d: data=%02h lat=%0d, required data=%02h lat=8",
                 i, got, lat, pt[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pt [3];
    logic [7:0] got;
    int lat, warm, bad;
    for (int i = 0; i < 3; i++) pt[i] = 8'($urandom);
    load_seed(8'h76, 1'b1, warm);
    xfer(pt[0] ^ mks[0], 1'b1, got, lat);
    checks++;
    if (got !== pt[0] || lat != 8) begin
      failures++;
      $display("FAIL bp_byte0: data=%02h lat=%0d, required data=%02h lat=8", got, lat, pt[0]);
    end
    out_ready = 1'b0;
    xfer(pt[1] ^ mks[1], 1'b0, got, lat);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid !== 1'b1 || out_data !== pt[1] || in_ready !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || lat != 8) begin
      failures++;
      $display("FAIL bp_hold: bad_cycles=%0d lat=%0d data=%02h, required 0 8 %02h",
               bad, lat, out_data, pt[1]);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    xfer(pt[2] ^ mks[2], 1'b1, got, lat);
    checks++;
    if (got !== pt[2] || lat != 8) begin
      failures++;
      $display("FAIL bp_byte2: data=%02h lat=%0d, required data=%02h lat=8", got, lat, pt[2]);
    end
  endtask

  task automatic test_resync_mid_crypt();
    logic [7:0] pt, got;
    int lat, warm;
    pt = 8'($urandom);
    load_seed(8'h76, 1'b1, warm);
    in_valid = 1'b1;
    in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    resync = 1'b1;
    tick();
    resync = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || seed_ready !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL resync_state: out_valid=%b busy=%b seed_ready=%b in_ready=%b, required 0 0 1 0",
               out_valid, busy, seed_ready, in_ready);
    end
    repeat (10) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL resync_no_out: out_valid=%b, required 0", out_valid);
    end
    load_seed(8'h76, 1'b1, warm);
    xfer(pt ^ mks[0], 1'b1, got, lat);
    checks++;
    if (got !== pt || lat != 8) begin
      failures++;
      $display("FAIL resync_first_byte: data=%02h lat=%0d, required data=%02h lat=8", got, lat, pt);
    end
  endtask

  task automatic test_seed_diff();
    logic [7:0] ct, got0, got1, exp0;
    int lat, warm;
    ct = 8'($urandom);
    load_seed(8'h00, 1'b1, warm);
    exp0 = ct ^ mks[0];
    xfer(ct, 1'b1, got0, lat);
    checks++;
    if (got0 !== exp0 || lat != 8) begin
      failures++;
      $display("FAIL seed00: data=%02h lat=%0d, required data=%02h lat=8", got0, lat, exp0);
    end
    load_seed(8'h01, 1'b1, warm);
    xfer(ct, 1'b1, got1, lat);
    checks++;
    if (got1 !== (ct ^ mks[0]) || lat != 8) begin
      failures++;
      $display("FAIL seed01: data=%02h lat=%0d, required data=%02h lat=8", got1, lat, ct ^ mks[0]);
    end
    checks++;
    if (got0 === got1) begin
      failures++;
      $display("FAIL seed_diff: seed00 out=%02h seed01 out=%02h, required different", got0, got1);
    end
  endtask

  task automatic test_seed_resync_collision();
    logic [7:0] pt, got;
    int lat, warm, bad;
    pt = 8'($urandom);
    load_seed(8'h33, 1'b1, warm);
    seed = 8'h76;
    seed_valid = 1'b1;
    resync = 1'b1;
    tick();
    seed_valid = 1'b0;
    resync = 1'b0;
    checks++;
    if (seed_ready !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL collision: seed_ready=%b busy=%b in_ready=%b, required 1 0 0",
               seed_ready, busy, in_ready);
    end
    in_valid = 1'b1;
    in_data = 8'h5A;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_in_valid: bad_cycles=%0d, required 0", bad);
    end
    load_seed(8'h76, 1'b1, warm);
    xfer(pt ^ mks[0], 1'b1, got, lat);
    checks++;
    if (got !== pt || lat != 8) begin
      failures++;
      $display("FAIL post_idle_byte: data=%02h lat=%0d, required data=%02h lat=8", got, lat, pt);
    end
  endtask

  task automatic test_random_stream();
    logic [7:0] pt, got;
    int lat, warm, stall;
    load_seed(8'($urandom), 1'b1, warm);
    for (int i = 0; i < 8; i++) begin
      pt = 8'($urandom);
      stall = int'($urandom_range(0, 4));
      out_ready = (stall == 0);
      xfer(pt ^ mks[i], 1'b0, got, lat);
      repeat (stall) tick();
      out_ready = 1'b1;
      tick();
      checks++;
      if (got !== pt || lat != 8 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL random_byte%0d: data=%02h lat=%0d out_valid=%b, required data=%02h lat=8 out_valid=0",
                 i, got, lat, out_valid, pt);
      end
    end
  endtask

`ifdef TRIVIUM_RX_BYTE_COUNT_EN
  task automatic test_byte_count();
    logic [7:0] got;
    int lat, warm;
    load_seed(8'h76, 1'b1, warm);
    checks++;
    if (byte_count !== 16'd0) begin
      failures++;
      $display("FAIL count_reseed: byte_count=%0d, required 0", byte_count);
    end
    for (int i = 0; i < 4; i++) xfer(8'($urandom), 1'b1, got, lat);
    checks++;
    if (byte_count !== 16'd4) begin
      failures++;
      $display("FAIL count_four: byte_count=%0d, required 4", byte_count);
    end
    load_seed(8'h12, 1'b1, warm);
    checks++;
    if (byte_count !== 16'd0) begin
      failures++;
      $display("FAIL count_clear: byte_count=%0d, required 0", byte_count);
    end
  endtask
`endif

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_known_vector();
    test_backpressure();
    test_resync_mid_crypt();
    test_seed_diff();
    test_seed_resync_collision();
    test_random_stream();
`ifdef TRIVIUM_RX_BYTE_COUNT_EN
    test_byte_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
